// File: rtl/fp_mul_pipe_param.sv
// Three-stage pipelined multiplier for unsigned (sign-less) floats {exp, man}.
// Denormal inputs count as zero. Results never encode Inf/NaN: they saturate to
// the largest finite value (ovf) or flush to zero (unf). A TAG_W side-band word
// travels with every operation.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   in_valid / in_ready      operand handshake; in_ready is the pipeline enable
//   float_in_1, float_in_2   operands {exp[EXP_W], man[MAN_W]}
//   tag_in                   side-band word carried alongside the operation
//   out_valid / out_ready    result handshake
//   float_out, tag_out       product and its tag
//   ovf, unf                 saturated / flushed-to-zero flags, qualified by out_valid
module fp_mul_pipe_param #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned TAG_W = 31,
  parameter int unsigned ROUND = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W-1:0] float_in_1,
  input  logic [EXP_W+MAN_W-1:0] float_in_2,
  input  logic [TAG_W-1:0]       tag_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W-1:0] float_out,
  output logic [TAG_W-1:0]       tag_out,
  output logic                   ovf,
  output logic                   unf
);

  localparam int unsigned FW = EXP_W + MAN_W;
  localparam int unsigned PW = 2 * MAN_W + 2;
  localparam int unsigned EW = EXP_W + 2;

  localparam logic signed [EW-1:0] Bias   = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] ExpMax = EW'((1 << EXP_W) - 1);
  localparam logic [EXP_W-1:0]     ExpSat = EXP_W'((1 << EXP_W) - 2);

  // All stages advance together; a stalled output freezes the whole pipe.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage 1: raw mantissa product and biased exponent sum
  logic                 s1_valid_q, s1_zero_q;
  logic [PW-1:0]        s1_prod_q;
  logic signed [EW-1:0] s1_exp_q;
  logic [TAG_W-1:0]     s1_tag_q;

  logic [EXP_W-1:0]     exp_a, exp_b;
  logic [PW-1:0]        s1_prod_d;
  logic signed [EW-1:0] s1_exp_d;
  logic                 s1_zero_d;

  always_comb begin
    exp_a     = float_in_1[FW-1:MAN_W];
    exp_b     = float_in_2[FW-1:MAN_W];
    s1_zero_d = (exp_a == '0) || (exp_b == '0);
    s1_prod_d = PW'({1'b1, float_in_1[MAN_W-1:0]}) * PW'({1'b1, float_in_2[MAN_W-1:0]});
    s1_exp_d  = signed'(EW'(exp_a)) + signed'(EW'(exp_b)) - Bias;
  end

  // Stage 2: normalise and round
  logic                 s2_valid_q, s2_zero_q;
  logic [MAN_W-1:0]     s2_man_q;
  logic signed [EW-1:0] s2_exp_q;
  logic [TAG_W-1:0]     s2_tag_q;

  logic                 norm, guard, sticky, inc, carry;
  logic [MAN_W-1:0]     man_t, man_r;
  logic signed [EW-1:0] s2_exp_d;

  always_comb begin
    norm = s1_prod_q[PW-1];
    if (norm) begin
      man_t  = s1_prod_q[PW-2 -: MAN_W];
      guard  = s1_prod_q[MAN_W];
      sticky = |s1_prod_q[MAN_W-1:0];
    end else begin
      man_t  = s1_prod_q[PW-3 -: MAN_W];
      guard  = s1_prod_q[MAN_W-1];
      sticky = |s1_prod_q[MAN_W-2:0];
    end
    inc = (ROUND != 0) && guard && (sticky || man_t[0]);
    // A carry out of an all-ones mantissa leaves man_r at zero: that is the
    // renormalised 1.0 significand, only the exponent needs bumping.
    {carry, man_r} = {1'b0, man_t} + (MAN_W + 1)'(inc);
    s2_exp_d = s1_exp_q + signed'(EW'(norm)) + signed'(EW'(carry));
  end

  // Stage 3: range check and packing
  logic [FW-1:0] float_d;
  logic          ovf_d, unf_d;

  always_comb begin
    float_d = '0;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (s2_zero_q) begin
      float_d = '0;
    end else if (s2_exp_q <= 0) begin
      unf_d = 1'b1;
    end else if (s2_exp_q >= ExpMax) begin
      float_d = {ExpSat, {MAN_W{1'b1}}};
      ovf_d   = 1'b1;
    end else begin
      float_d = {s2_exp_q[EXP_W-1:0], s2_man_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_prod_q  <= '0;
      s1_exp_q   <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_man_q   <= '0;
      s2_exp_q   <= '0;
      s2_tag_q   <= '0;
      out_valid  <= 1'b0;
      float_out  <= '0;
      tag_out    <= '0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
    end else if (en) begin
      s1_valid_q <= in_valid;
      s1_zero_q  <= s1_zero_d;
      s1_prod_q  <= s1_prod_d;
      s1_exp_q   <= s1_exp_d;
      s1_tag_q   <= tag_in;
      s2_valid_q <= s1_valid_q;
      s2_zero_q  <= s1_zero_q;
      s2_man_q   <= man_r;
      s2_exp_q   <= s2_exp_d;
      s2_tag_q   <= s1_tag_q;
      out_valid  <= s2_valid_q;
      float_out  <= float_d;
      tag_out    <= s2_tag_q;
      ovf        <= ovf_d;
      unf        <= unf_d;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe_param.sv
// Scoreboard bench for fp_mul_pipe_param: a round-to-nearest-even instance and a
// truncating instance share stimulus; expected results from an integer model are
// queued on each accepted operation and compared as results leave the pipe.
module tb_fp_mul_pipe_param;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned TAG_W = 31;
  localparam int unsigned FW    = EXP_W + MAN_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_ready_rz;
  logic [FW-1:0] float_in_1, float_in_2;
  logic [TAG_W-1:0] tag_in;
  logic          out_valid, out_ready, out_valid_rz;
  logic [FW-1:0] float_out, float_out_rz;
  logic [TAG_W-1:0] tag_out, tag_out_rz;
  logic          ovf, unf, ovf_rz, unf_rz;

  always #5 clk = ~clk;

  fp_mul_pipe_param #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W), .ROUND(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .float_in_1(float_in_1), .float_in_2(float_in_2), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .float_out(float_out),
    .tag_out(tag_out), .ovf(ovf), .unf(unf)
  );

  fp_mul_pipe_param #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W), .ROUND(0)) dut_rz (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_rz),
    .float_in_1(float_in_1), .float_in_2(float_in_2), .tag_in(tag_in),
    .out_valid(out_valid_rz), .out_ready(out_ready), .float_out(float_out_rz),
    .tag_out(tag_out_rz), .ovf(ovf_rz), .unf(unf_rz)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_in  = 0;
  int n_out = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: {ovf, unf, float} from integer arithmetic.
  function automatic logic [FW+1:0] model(input logic [FW-1:0] a, input logic [FW-1:0] b,
                                          input bit rne);
    longint unsigned ma, mb, p, m, rem, half;
    int e, sh;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return '0;
    ma = {40'd0, 1'b1, a[22:0]};
    mb = {40'd0, 1'b1, b[22:0]};
    p  = ma * mb;
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    sh = p[47] ? 24 : 23;
    if (p[47]) e++;
    m    = p >> sh;
    rem  = p & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (rne && (rem > half || (rem == half && m[0]))) m++;
    if (m == (64'd1 << 24)) begin
      m = m >> 1;
      e++;
    end
    if (e <= 0) return {1'b0, 1'b1, 31'd0};
    if (e >= 255) return {1'b1, 1'b0, 31'h7F7F_FFFF};
    return {2'b00, 8'(e), m[22:0]};
  endfunction

  typedef struct packed {
    logic [FW+1:0]    r1;
    logic [FW+1:0]    r0;
    logic [TAG_W-1:0] tag;
  } sb_t;

  sb_t sb[$];

  // Monitor: outputs popped before the reset flush so a same-cycle hand-off is
  // still scored; inputs pushed only when the coming edge really accepts them.
  always @(negedge clk) begin
    sb_t e;
    if (out_valid && out_ready) begin
      n_out++;
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("float_out", 64'(float_out), 64'(e.r1[FW-1:0]));
        check("ovf", 64'(ovf), 64'(e.r1[FW+1]));
        check("unf", 64'(unf), 64'(e.r1[FW]));
        check("tag_out", 64'(tag_out), 64'(e.tag));
        check("float_out_rz", 64'(float_out_rz), 64'(e.r0[FW-1:0]));
        check("flags_rz", 64'({ovf_rz, unf_rz}), 64'(e.r0[FW+1:FW]));
        check("tag_out_rz", 64'(tag_out_rz), 64'(e.tag));
      end
    end
    if (rst) begin
      sb.delete();
    end else if (in_valid && in_ready) begin
      e.r1  = model(float_in_1, float_in_2, 1'b1);
      e.r0  = model(float_in_1, float_in_2, 1'b0);
      e.tag = tag_in;
      sb.push_back(e);
      n_in++;
    end
  end

  // Single directed op with out_ready high; entered and left at #1 after an edge.
  task automatic run_one(input logic [FW-1:0] a, input logic [FW-1:0] b,
                         input logic [TAG_W-1:0] t, input logic [FW-1:0] e1,
                         input logic [FW-1:0] e0, input logic eo, input logic eu);
    int lat;
    float_in_1 = a;
    float_in_2 = b;
    tag_in     = t;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    @(negedge clk);
    check("one_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'd3);
    check("one_float", 64'(float_out), 64'(e1));
    check("one_float_rz", 64'(float_out_rz), 64'(e0));
    check("one_tag", 64'(tag_out), 64'(t));
    check("one_ovf", 64'(ovf), 64'(eo));
    check("one_unf", 64'(unf), 64'(eu));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] rnd_op();
    logic [7:0]  ex;
    logic [22:0] mn;
    case ($urandom_range(0, 9))
      0:       ex = 8'd0;
      1:       ex = 8'd255;
      2, 3:    ex = 8'($urandom_range(0, 255));
      default: ex = 8'($urandom_range(100, 154));
    endcase
    mn = ($urandom_range(0, 7) == 0) ? 23'h7F_FFFF : 23'($urandom);
    return {ex, mn};
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [FW-1:0] held;
    int sent, base_in, base_out, guard_cnt;
    bit fire;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    float_in_1 = '0;
    float_in_2 = '0;
    tag_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_float_out", 64'(float_out), 64'd0);
    check("rst_tag_out", 64'(tag_out), 64'd0);
    check("rst_flags", 64'({ovf, unf}), 64'd0);
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed values
    run_one(31'h4000_0000, 31'h4040_0000, 31'h1234, 31'h40C0_0000, 31'h40C0_0000, 1'b0, 1'b0);
    run_one(31'h3F80_0001, 31'h3FC0_0000, 31'h11, 31'h3FC0_0002, 31'h3FC0_0001, 1'b0, 1'b0);
    run_one(31'h3F80_0001, 31'h3F80_0001, 31'h22, 31'h3F80_0002, 31'h3F80_0002, 1'b0, 1'b0);
    run_one(31'h7F00_0000, 31'h4000_0000, 31'h33, 31'h7F7F_FFFF, 31'h7F7F_FFFF, 1'b1, 1'b0);
    run_one(31'h0080_0000, 31'h3F00_0000, 31'h44, 31'h0, 31'h0, 1'b0, 1'b1);
    run_one(31'h0000_0000, 31'h4000_0000, 31'h55, 31'h0, 31'h0, 1'b0, 1'b0);
    run_one(31'h7F80_0000, 31'h3F00_0000, 31'h66, 31'h7F00_0000, 31'h7F00_0000, 1'b0, 1'b0);

    // Back-to-back stream with a stall in cycles 4..9
    base_out = n_out;
    sent = 0;
    for (int c = 0; c < 40; c++) begin
      out_ready  = !(c >= 4 && c <= 9);
      in_valid   = (sent < 8);
      float_in_1 = 31'h3F80_0000 + 31'(sent) * 31'h0012_3457;
      float_in_2 = 31'h3FA0_0000 + 31'(sent) * 31'h0009_8765;
      tag_in     = 31'h100 + 31'(sent);
      @(negedge clk);
      fire = in_valid && in_ready;
      if (c == 4) held = float_out;
      if (c == 6) begin
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
      end
      if (c == 9) check("stall_hold", 64'(float_out), 64'(held));
      if (c >= 10 && c <= 16) check("stream_no_gap", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;
      if (fire) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_count", 64'(n_out - base_out), 64'd8);

    // Reset with three operations in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid   = 1'b1;
      float_in_1 = 31'h4000_0000 + 31'(i);
      float_in_2 = 31'h4040_0000;
      tag_in     = 31'h7000 + 31'(i);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_float_out", 64'(float_out), 64'd0);
    check("mid_rst_tag_out", 64'(tag_out), 64'd0);
    check("mid_rst_flags", 64'({ovf, unf}), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    run_one(31'h4000_0000, 31'h4000_0000, 31'h77, 31'h4080_0000, 31'h4080_0000, 1'b0, 1'b0);

    // Random traffic
    base_in  = n_in;
    base_out = n_out;
    sent = 0;
    while (sent < 10000) begin
      out_ready  = ($urandom_range(0, 3) != 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      float_in_1 = rnd_op();
      float_in_2 = rnd_op();
      tag_in     = 31'($urandom);
      @(negedge clk);
      fire = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (fire) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard_cnt = 0;
    while (sb.size() != 0 && guard_cnt < 50) begin
      @(posedge clk);
      #1;
      guard_cnt++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    check("io_count", 64'(n_out - base_out), 64'(n_in - base_in));
    check("rand_in_count", 64'(n_in - base_in), 64'd10000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_mul_pipe_param.md
Name: fp_mul_pipe_param

Overview:
- Parametrised, backpressure-capable successor to the fixed 31-bit two-stage unsigned float multiplier used in the inverse-square-root datapath.
- Multiplies two unsigned (sign-less) floats of EXP_W exponent and MAN_W mantissa bits.
- Generalisations: selectable rounding, saturation and flush-to-zero handling, status flags, and a TAG_W side-band word carried with each operation.
- Feeds the Newton-iteration stages. The side-band replaces the old fixed delayed-operand output.

Parameters:
- EXP_W, 8: exponent field width; bias B = 2^(EXP_W-1)-1.
- MAN_W, 23: stored mantissa width (hidden 1 implied).
- TAG_W, 31: side-band width, passed through unmodified.
- ROUND, 1: 0 = truncate, 1 = round-to-nearest-even (RNE).

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: synchronous reset, active-high.
- in_valid, in, 1: operands valid.
- in_ready, out, 1: block accepts an operation this cycle.
- float_in_1, in, EXP_W+MAN_W: operand A, {exp, man}.
- float_in_2, in, EXP_W+MAN_W: operand B.
- tag_in, in, TAG_W: side-band word.
- out_valid, out, 1: result valid.
- out_ready, in, 1: consumer accepts the result.
- float_out, out, EXP_W+MAN_W: product.
- tag_out, out, TAG_W: tag_in of the same operation.
- ovf, out, 1: result saturated; qualified by out_valid.
- unf, out, 1: result flushed to zero by underflow; qualified by out_valid.

Behaviour:
- Reset: all stage valid bits = 0; out_valid, float_out, tag_out, ovf and unf = 0. Reset mid-operation discards all in-flight operations. in_ready = 1 in the first cycle after reset.
- Pipeline: 3 register stages, all sharing one enable `en = !out_valid || out_ready`. in_ready = en (combinational). An operation transfers on `in_valid && in_ready`.
- Latency: exactly 3 cycles from transfer to out_valid when out_ready is held high. Throughput is 1 operation per cycle.
- Stall: when `out_valid && !out_ready`, every stage, float_out, tag_out and the flags hold stable. A bubble is not overwritten, so no loss and no duplication. Order is strictly preserved.
- S1:
  - Mantissa product P = {1,manA} * {1,manB}, width 2*MAN_W+2.
  - Exponent sum E = expA + expB - B, held signed with width EXP_W+2.
  - zero = (expA==0) || (expB==0); denormal inputs are treated as zero.
  - Tag registered.
- S2:
  - Normalise: if P[MSB] = 1, shift right by 1 and set E += 1.
  - Round to MAN_W bits using guard bit and sticky bit.
  - RNE: increment when `guard && (sticky || lsb)`.
  - If rounding carries out of the mantissa, renormalise: mantissa = 0, E += 1.
- S3:
  - zero → float_out = 0, flags = 0.
  - Else if E <= 0 → float_out = 0, unf = 1.
  - Else if E >= 2^EXP_W-1 → float_out = {2^EXP_W-2, all-ones mantissa} (largest finite value), ovf = 1.
  - Else {E[EXP_W-1:0], mantissa}.
  - No Inf/NaN encodings are ever produced. An input exponent of all ones is treated as an ordinary value.
- in_valid low inserts a bubble. out_valid then deasserts in the matching output cycle.

Test Plan (defaults, ROUND=1 unless stated):
1. 0x40000000 × 0x40400000 (2.0×3.0), tag 0x1234, out_ready=1 → 3 cycles later float_out=0x40C00000, tag_out=0x1234, ovf=unf=0.
2. 0x3F800001 × 0x3FC00000 (tie case) → ROUND=1: 0x3FC00002. ROUND=0 build: 0x3FC00001. Also 0x3F800001 × 0x3F800001 → 0x3F800002 under both modes.
3. 0x7F000000 × 0x40000000 → 0x7F7FFFFF, ovf=1. 0x00800000 × 0x3F000000 → 0x00000000, unf=1. 0x00000000 × 0x40000000 → 0, flags 0.
4. Back-to-back stream of 8 ops with out_ready=0 during cycles 4–9 → in_ready drops once the 3 stages and the output are held. All 8 results emerge in order with correct tags, with no gaps once out_ready returns.
5. Assert rst for 1 cycle while 3 ops are in flight → next cycle out_valid=0 and outputs are 0. A new op afterwards returns after exactly 3 cycles. None of the discarded ops appear.
6. Random in_valid/out_ready pattern, 10k ops, against a reference model (RNE, saturate, flush) → bit-exact float_out, tag_out and flags; count of outputs equals count of inputs.
